bsg_test_node_client_loopback: RTL and testbench

BSG_TEST_NODE_CLIENT_LOOPBACK -- requirements
Module: bsg_test_node_client_loopback

---
 rtl/bsg_chip_pkg.sv | 7 +
 rtl/bsg_fsb_pkg.sv | 11 +
 rtl/bsg_fifo_1r1w_small.sv | 58 +++++
 rtl/bsg_test_node_client_loopback.sv | 78 +++++++
 tb/tb_bsg_test_node_client_loopback.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bsg_chip_pkg.sv
// Chip-level FSB configuration: ring width and node ids.
// Values used when instantiating test nodes.
package bsg_chip_pkg;
  localparam int ring_width_gp = 16;
  localparam int master_id_gp  = 0;
  localparam int client_id_gp  = 2;
endpackage

// File: rtl/bsg_fsb_pkg.sv
// FSB ring shared constants: dest-id field geometry.
// The dest id sits at the top of every ring packet.
package bsg_fsb_pkg;
  localparam int fsb_id_width_gp  = 4;
  // Distance of the id field's msb below the packet msb.
  localparam int fsb_id_offset_gp = 0;

  function automatic int fsb_id_msb(input int ring_width);
    return ring_width - 1 - fsb_id_offset_gp;
  endfunction
endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1r1w FIFO, valid-ready in, valid-yumi out.
// Ports: clk_i, reset_i, v_i/ready_o/data_i, v_o/data_o/yumi_i.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int PW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CW = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_cnt;
  logic               w_enq;
  logic               w_deq;

  // No enqueue bypass when full, even with a dequeue.
  assign ready_o = (r_cnt != CW'(els_p));
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= inc(r_wptr);
      if (w_deq) r_rptr <= inc(r_rptr);
      unique case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/bsg_test_node_client_loopback.sv
// FSB client test node: returns packets addressed to it to the master.
// Ports: clk_i/reset_i, en_i, v_i/data_i/ready_o in, v_o/data_o/yumi_i out, pkt_count_o, error_o.
module bsg_test_node_client_loopback
  import bsg_fsb_pkg::*;
#(
  parameter int ring_width_p = bsg_chip_pkg::ring_width_gp,
  parameter int master_id_p  = bsg_chip_pkg::master_id_gp,
  parameter int client_id_p  = bsg_chip_pkg::client_id_gp,
  parameter int els_p        = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic [31:0]             pkt_count_o,
  output logic                    error_o
);
  localparam int MSB = fsb_id_msb(ring_width_p);
  localparam int IW  = fsb_id_width_gp;

  logic                    w_fifo_ready;
  logic                    w_fifo_v;
  logic                    w_accept;
  logic                    w_match;
  logic                    w_enq;
  logic                    w_deq;
  logic [ring_width_p-1:0] w_rewr;
  logic [31:0]             r_pkt_count;
  logic                    r_error;

  assign ready_o  = ~reset_i & w_fifo_ready;
  assign w_accept = v_i & ready_o;
  assign w_match  = (data_i[MSB -: IW] == IW'(client_id_p));
  assign w_enq    = w_accept & w_match;

  always_comb begin
    w_rewr           = data_i;
    w_rewr[MSB -: IW] = IW'(master_id_p);
  end

  // Reset is folded in so stale entries never show in a reset cycle.
  assign v_o   = en_i & w_fifo_v & ~reset_i;
  assign w_deq = yumi_i & v_o;

  bsg_fifo_1r1w_small #(
    .width_p(ring_width_p),
    .els_p  (els_p)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (w_enq),
    .ready_o(w_fifo_ready),
    .data_i (w_rewr),
    .v_o    (w_fifo_v),
    .data_o (data_o),
    .yumi_i (w_deq)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pkt_count <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_deq && r_pkt_count != 32'hFFFF_FFFF)
        r_pkt_count <= r_pkt_count + 32'd1;
      if (w_accept && !w_match)
        r_error <= 1'b1;
    end
  end

  assign pkt_count_o = reset_i ? 32'd0 : r_pkt_count;
  assign error_o     = r_error & ~reset_i;
endmodule

// File: tb/tb_bsg_test_node_client_loopback.sv
// Directed bench for bsg_test_node_client_loopback.
// Client id 2, master id 0, 16-bit packets, depth 4.
module tb_bsg_test_node_client_loopback;
  localparam int RW = bsg_chip_pkg::ring_width_gp;

  logic          clk = 1'b0;
  logic          reset_i, en_i, v_i, yumi_i;
  logic [RW-1:0] data_i;
  logic          ready_o, v_o, error_o;
  logic [RW-1:0] data_o;
  logic [31:0]   pkt_count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_test_node_client_loopback #(
    .ring_width_p(RW),
    .master_id_p (bsg_chip_pkg::master_id_gp),
    .client_id_p (bsg_chip_pkg::client_id_gp),
    .els_p       (4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .pkt_count_o(pkt_count_o),
    .error_o    (error_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // yumi_i without v_o is an illegal stimulus.
  always @(negedge clk) begin
    if (!reset_i && yumi_i) begin
      assert (v_o) else begin
        fails++;
        $error("FAIL yumi_no_v observed=%0b expected=1", v_o);
      end
    end
  end

  initial begin : seq
    int nret;
    int nv;
    logic [RW-1:0] expd;
    reset_i = 1'b1; en_i = 1'b1;
    v_i = 1'b1; yumi_i = 1'b0;
    data_i = 16'h2FFF;
    #1;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_v", 32'(v_o), 0);
    tick(); tick();
    chk("rst_cnt", pkt_count_o, 0);
    chk("rst_err", 32'(error_o), 0);
    chk("rst_v2", 32'(v_o), 0);
    reset_i = 1'b0; v_i = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready_o), 1);

    // single packet
    v_i = 1'b1; data_i = 16'h2ABC;
    #1;
    chk("s_v_same", 32'(v_o), 0);
    tick();
    v_i = 1'b0;
    chk("s_v", 32'(v_o), 1);
    chk("s_data", 32'(data_o), 32'h0ABC);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("s_cnt", pkt_count_o, 1);
    chk("s_empty", 32'(v_o), 0);

    // fill and full
    for (int i = 1; i <= 4; i++) begin
      v_i = 1'b1; data_i = RW'(16'h2000 + i);
      tick();
    end
    data_i = 16'h2005;
    #1;
    chk("f_ready0", 32'(ready_o), 0);
    tick();
    chk("f_ready1", 32'(ready_o), 0);
    chk("f_head", 32'(data_o), 32'h0001);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("f_ready2", 32'(ready_o), 1);
    chk("f_head2", 32'(data_o), 32'h0002);
    tick();
    v_i = 1'b0;
    chk("f_ready3", 32'(ready_o), 0);
    for (int i = 2; i <= 5; i++) begin
      chk("f_order", 32'(data_o), 32'(i));
      yumi_i = 1'b1;
      tick();
    end
    yumi_i = 1'b0;
    chk("f_cnt", pkt_count_o, 6);
    chk("f_empty", 32'(v_o), 0);

    // misroute
    v_i = 1'b1; data_i = 16'h5123;
    #1;
    chk("m_ready", 32'(ready_o), 1);
    tick();
    v_i = 1'b0;
    chk("m_err", 32'(error_o), 1);
    chk("m_nov", 32'(v_o), 0);
    tick();
    chk("m_err_sticky", 32'(error_o), 1);
    v_i = 1'b1; data_i = 16'h2777;
    tick();
    v_i = 1'b0;
    chk("m_next_v", 32'(v_o), 1);
    chk("m_next_d", 32'(data_o), 32'h0777);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("m_err_still", 32'(error_o), 1);
    chk("m_cnt", pkt_count_o, 7);

    // enable gating
    en_i = 1'b0;
    v_i = 1'b1; data_i = 16'h2011;
    tick();
    data_i = 16'h2022;
    tick();
    v_i = 1'b0;
    chk("e_v_off", 32'(v_o), 0);
    tick();
    chk("e_v_off2", 32'(v_o), 0);
    en_i = 1'b1;
    #1;
    chk("e_v_on", 32'(v_o), 1);
    chk("e_d1", 32'(data_o), 32'h0011);
    yumi_i = 1'b1;
    tick();
    chk("e_d2", 32'(data_o), 32'h0022);
    tick();
    yumi_i = 1'b0;
    chk("e_empty", 32'(v_o), 0);
    chk("e_cnt", pkt_count_o, 9);

    // reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      v_i = 1'b1; data_i = RW'(16'h2030 + i);
      tick();
    end
    v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("r_v", 32'(v_o), 0);
    chk("r_cnt", pkt_count_o, 0);
    chk("r_err", 32'(error_o), 0);
    chk("r_ready", 32'(ready_o), 0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("r_v_after", 32'(v_o), 0);
    chk("r_err_after", 32'(error_o), 0);
    tick();
    chk("r_stale", 32'(v_o), 0);
    chk("r_cnt_after", pkt_count_o, 0);

    // streaming
    nret = 0; nv = 0;
    for (int c = 0; c < 102; c++) begin
      v_i = (c < 100);
      data_i = RW'(16'h2000 + c);
      #1;
      yumi_i = v_o;
      if (c >= 1 && c <= 100) nv += int'(v_o);
      if (v_o) begin
        expd = RW'(nret);
        chk("st_data", 32'(data_o), 32'(expd));
        nret++;
      end
      tick();
      yumi_i = 1'b0;
    end
    v_i = 1'b0;
    chk("st_nret", 32'(nret), 100);
    chk("st_thru", 32'(nv), 100);
    chk("st_cnt", pkt_count_o, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
